pc_gen: RTL and testbench

- Parametrised fetch-address generator for the IF stage; successor to the fixed 32-bit program-counter register.
- Adds a configurable width, reset vector and instruction step.
- Adds a flush/exception redirect and an instruction-memory ready input (wait states).
- Adds a one-entry pending-branch buffer, so a branch resolved while fetch is held is not lost.
- Drives the instruction-memory address and chip-enable.

---
 rtl/pc_gen.sv | 107 ++++++++++
 tb/tb_pc_gen.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/pc_gen.sv
// pc_gen: fetch-address generator for the IF stage.
//
// Holds the program counter and the instruction-memory chip enable. It
// advances sequentially by INST_BYTES when fetch is allowed. It redirects on
// a flush (highest priority, not affected by stall or wait states) or on a
// taken branch. A branch that resolves while fetch is held is kept in a
// one-entry pending buffer and taken on the next advancing cycle.
//
// Ports:
//   clk                      clock, rising edge
//   rst                      asynchronous active-high reset
//   stall[5:0]               pipeline stall vector; only stall[0] (IF hold) is used
//   inst_ready               instruction memory accepted the current fetch
//   flush / new_pc           exception/interrupt redirect and its target
//   branch_flag_i            branch resolved taken this cycle
//   branch_target_address_i  branch target
//   pc                       current fetch address (registered)
//   ce                       instruction-memory chip enable (registered)
//   pc_misaligned            pc is not a multiple of INST_BYTES
//   pend_valid               a branch is buffered (registered)
module pc_gen #(
    parameter int unsigned       ADDR_W     = 32,
    parameter logic [ADDR_W-1:0] RESET_VEC  = '0,
    parameter int unsigned       INST_BYTES = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [5:0]        stall,
    input  logic              inst_ready,
    input  logic              flush,
    input  logic [ADDR_W-1:0] new_pc,
    input  logic              branch_flag_i,
    input  logic [ADDR_W-1:0] branch_target_address_i,
    output logic [ADDR_W-1:0] pc,
    output logic              ce,
    output logic              pc_misaligned,
    output logic              pend_valid
);

    localparam logic [ADDR_W-1:0] Step      = ADDR_W'(INST_BYTES);
    // The mask is zero when INST_BYTES is 1, so pc_misaligned is then always 0.
    localparam logic [ADDR_W-1:0] AlignMask = ADDR_W'(INST_BYTES - 1);

    logic [ADDR_W-1:0] pc_q, pc_d;
    logic              ce_q, ce_d;
    logic              pend_valid_q, pend_valid_d;
    logic [ADDR_W-1:0] pend_tgt_q, pend_tgt_d;
    logic              advance;

    // The upper stall bits belong to later pipeline stages.
    logic unused_stall;
    assign unused_stall = ^stall[5:1];

    assign advance = ce_q & ~stall[0] & inst_ready;

    always_comb begin
        pc_d         = pc_q;
        ce_d         = ce_q;
        pend_valid_d = pend_valid_q;
        pend_tgt_d   = pend_tgt_q;

        if (!ce_q) begin
            // First cycle out of reset: enable fetch at the reset vector.
            ce_d         = 1'b1;
            pc_d         = RESET_VEC;
            pend_valid_d = 1'b0;
            pend_tgt_d   = '0;
        end else if (flush) begin
            pc_d         = new_pc;
            pend_valid_d = 1'b0;
        end else if (advance) begin
            pend_valid_d = 1'b0;
            if (branch_flag_i) begin
                // A fresh branch supersedes any buffered one.
                pc_d = branch_target_address_i;
            end else if (pend_valid_q) begin
                pc_d = pend_tgt_q;
            end else begin
                pc_d = pc_q + Step;
            end
        end else if (branch_flag_i) begin
            // Fetch is held: remember the branch; a later one overwrites it.
            pend_tgt_d   = branch_target_address_i;
            pend_valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q         <= RESET_VEC;
            ce_q         <= 1'b0;
            pend_valid_q <= 1'b0;
            pend_tgt_q   <= '0;
        end else begin
            pc_q         <= pc_d;
            ce_q         <= ce_d;
            pend_valid_q <= pend_valid_d;
            pend_tgt_q   <= pend_tgt_d;
        end
    end

    assign pc            = pc_q;
    assign ce            = ce_q;
    assign pend_valid    = pend_valid_q;
    assign pc_misaligned = |(pc_q & AlignMask);

endmodule

// File: tb/tb_pc_gen.sv
// Testbench for pc_gen: a 32-bit instance (reset vector BFC00000) and a
// 16-bit instance (reset vector FFF0) share the clock and reset. Each step
// pushes the expected outputs to a scoreboard queue. After the next clock
// edge (or immediately, for asynchronous checks) the entry is popped and
// compared against the DUT.
module tb_pc_gen;

    typedef struct {
        string       tag;
        bit          is16;
        logic [31:0] pc;
        logic        ce;
        logic        pend;
        logic        mis;
    } exp_t;

    logic        clk;
    logic        rst;

    logic [5:0]  stall;
    logic        inst_ready, flush, branch;
    logic [31:0] new_pc, tgt;
    logic [31:0] pc32;
    logic        ce32, mis32, pend32;

    logic [5:0]  stall16;
    logic        inst_ready16, flush16, branch16;
    logic [15:0] new_pc16, tgt16;
    logic [15:0] pc16;
    logic        ce16, mis16, pend16;

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;

    pc_gen #(
        .ADDR_W    (32),
        .RESET_VEC (32'hBFC0_0000),
        .INST_BYTES(4)
    ) dut32 (
        .clk                    (clk),
        .rst                    (rst),
        .stall                  (stall),
        .inst_ready             (inst_ready),
        .flush                  (flush),
        .new_pc                 (new_pc),
        .branch_flag_i          (branch),
        .branch_target_address_i(tgt),
        .pc                     (pc32),
        .ce                     (ce32),
        .pc_misaligned          (mis32),
        .pend_valid             (pend32)
    );

    pc_gen #(
        .ADDR_W    (16),
        .RESET_VEC (16'hFFF0),
        .INST_BYTES(4)
    ) dut16 (
        .clk                    (clk),
        .rst                    (rst),
        .stall                  (stall16),
        .inst_ready             (inst_ready16),
        .flush                  (flush16),
        .new_pc                 (new_pc16),
        .branch_flag_i          (branch16),
        .branch_target_address_i(tgt16),
        .pc                     (pc16),
        .ce                     (ce16),
        .pc_misaligned          (mis16),
        .pend_valid             (pend16)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected misalignment derived from the expected pc (INST_BYTES = 4).
    task automatic push(input string tag, input bit is16, input logic [31:0] p,
                        input logic c, input logic pv);
        exp_t e;
        e.tag  = tag;
        e.is16 = is16;
        e.pc   = p;
        e.ce   = c;
        e.pend = pv;
        e.mis  = (p[1:0] != 2'b00);
        sb.push_back(e);
    endtask

    task automatic check_now();
        exp_t        e;
        logic [31:0] o_pc;
        logic        o_ce, o_pend, o_mis;
        if (sb.size() == 0) begin
            total++;
            bad++;
            $error("FAIL scoreboard_empty observed=0 entries required=1");
            return;
        end
        e      = sb.pop_front();
        o_pc   = e.is16 ? {16'h0000, pc16} : pc32;
        o_ce   = e.is16 ? ce16 : ce32;
        o_pend = e.is16 ? pend16 : pend32;
        o_mis  = e.is16 ? mis16 : mis32;
        total++;
        assert (o_pc === e.pc) else begin
            bad++;
            $error("FAIL %s.pc observed=%h expected=%h", e.tag, o_pc, e.pc);
        end
        total++;
        assert (o_ce === e.ce) else begin
            bad++;
            $error("FAIL %s.ce observed=%b expected=%b", e.tag, o_ce, e.ce);
        end
        total++;
        assert (o_pend === e.pend) else begin
            bad++;
            $error("FAIL %s.pend_valid observed=%b expected=%b", e.tag, o_pend, e.pend);
        end
        total++;
        assert (o_mis === e.mis) else begin
            bad++;
            $error("FAIL %s.pc_misaligned observed=%b expected=%b", e.tag, o_mis, e.mis);
        end
    endtask

    // Inputs change at posedge+1, so they are sampled at the following edge.
    task automatic tick();
        @(posedge clk);
        #1;
        check_now();
    endtask

    initial begin
        rst          = 1'b1;
        stall        = '0;
        inst_ready   = 1'b1;
        flush        = 1'b0;
        branch       = 1'b0;
        new_pc       = '0;
        tgt          = '0;
        stall16      = 6'b000001;
        inst_ready16 = 1'b1;
        flush16      = 1'b0;
        branch16     = 1'b0;
        new_pc16     = '0;
        tgt16        = '0;

        // Reset held for 3 cycles.
        #1;
        push("rst_t0", 1'b0, 32'hBFC0_0000, 1'b0, 1'b0);
        check_now();
        repeat (3) @(posedge clk);
        #1;
        push("rst_held", 1'b0, 32'hBFC0_0000, 1'b0, 1'b0);
        check_now();
        rst = 1'b0;
        push("start_ce", 1'b0, 32'hBFC0_0000, 1'b1, 1'b0); tick();
        push("seq1", 1'b0, 32'hBFC0_0004, 1'b1, 1'b0); tick();
        push("seq2", 1'b0, 32'hBFC0_0008, 1'b1, 1'b0); tick();

        // Move to 0x10, then a free-running branch.
        flush = 1'b1; new_pc = 32'h10;
        push("flush_10", 1'b0, 32'h10, 1'b1, 1'b0); tick();
        flush = 1'b0;
        branch = 1'b1; tgt = 32'h100;
        push("br_100", 1'b0, 32'h100, 1'b1, 1'b0); tick();
        branch = 1'b0;
        push("seq_104", 1'b0, 32'h104, 1'b1, 1'b0); tick();

        // Stall with a branch buffered in cycle 2.
        stall = 6'b000001;
        push("stall_c1", 1'b0, 32'h104, 1'b1, 1'b0); tick();
        branch = 1'b1; tgt = 32'h200;
        push("stall_c2", 1'b0, 32'h104, 1'b1, 1'b1); tick();
        branch = 1'b0;
        push("stall_c3", 1'b0, 32'h104, 1'b1, 1'b1); tick();
        push("stall_c4", 1'b0, 32'h104, 1'b1, 1'b1); tick();
        stall = '0;
        push("pend_take", 1'b0, 32'h200, 1'b1, 1'b0); tick();
        push("seq_204", 1'b0, 32'h204, 1'b1, 1'b0); tick();

        // Wait states: two branches buffered, then flush discards them.
        inst_ready = 1'b0; branch = 1'b1; tgt = 32'h300;
        push("wait_br300", 1'b0, 32'h204, 1'b1, 1'b1); tick();
        tgt = 32'h400;
        push("wait_br400", 1'b0, 32'h204, 1'b1, 1'b1); tick();
        branch = 1'b0; flush = 1'b1; new_pc = 32'h80;
        push("wait_flush", 1'b0, 32'h80, 1'b1, 1'b0); tick();
        flush = 1'b0; inst_ready = 1'b1;
        push("seq_84", 1'b0, 32'h84, 1'b1, 1'b0); tick();
        stall = 6'b000001;
        push("hold_84", 1'b0, 32'h84, 1'b1, 1'b0); tick();

        // 16-bit instance: wrap and misaligned branch target.
        push("w16_idle", 1'b1, 32'hFFF0, 1'b1, 1'b0);
        check_now();
        flush16 = 1'b1; new_pc16 = 16'hFFFC;
        push("w16_flush", 1'b1, 32'hFFFC, 1'b1, 1'b0); tick();
        flush16 = 1'b0; stall16 = '0;
        push("w16_wrap", 1'b1, 32'h0000, 1'b1, 1'b0); tick();
        branch16 = 1'b1; tgt16 = 16'h0102;
        push("w16_mis", 1'b1, 32'h0102, 1'b1, 1'b0); tick();
        branch16 = 1'b0;
        push("w16_mis_seq", 1'b1, 32'h0106, 1'b1, 1'b0); tick();

        // Asynchronous reset mid-cycle with a branch pending.
        branch = 1'b1; tgt = 32'h500;
        push("pre_rst_pend", 1'b0, 32'h84, 1'b1, 1'b1); tick();
        branch = 1'b0;
        #3;
        rst = 1'b1;
        #1;
        push("async_rst", 1'b0, 32'hBFC0_0000, 1'b0, 1'b0);
        check_now();
        push("async_rst16", 1'b1, 32'hFFF0, 1'b0, 1'b0);
        check_now();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Safety net against a stuck simulation.
    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout required=finish");
        $fatal(1, "watchdog");
    end

endmodule
